// File: rtl/timer_capture_collector.sv
// -----------------------------------------------------------------------------
// timer_capture_collector
//
// Collects one-cycle capture strobes from NB_INSTANCES timer instances into a
// single first-word-fall-through FIFO. Each instance owns a one-entry holding
// register. A round-robin arbiter moves at most one held capture per cycle into
// the FIFO. A capture that arrives while the instance still holds an unsent
// value is dropped, and the instance's sticky overflow flag is set.
//
// Ports
//   i_clk              : single clock for all logic
//   i_areset           : asynchronous, active-high reset
//   i_cap_valid        : per-instance one-cycle capture strobe
//   i_cap_value        : captured values, instance i at [i*TIMER_BITWIDTH +: TIMER_BITWIDTH]
//   i_clear_overflow   : per-instance one-cycle clear of the sticky overflow flag
//   o_out_valid        : FIFO head entry valid
//   i_out_ready        : consumer accepts the head when o_out_valid && i_out_ready
//   o_out_value        : captured value of the head entry
//   o_out_instance     : source instance index of the head entry
//   o_overflow         : sticky per-instance dropped-capture flags
//   o_fifo_count       : current FIFO occupancy
// -----------------------------------------------------------------------------
module timer_capture_collector #(
    parameter int TIMER_BITWIDTH = 32,
    parameter int NB_INSTANCES   = 10,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                                     i_clk,
    input  logic                                     i_areset,
    input  logic [NB_INSTANCES-1:0]                  i_cap_valid,
    input  logic [NB_INSTANCES*TIMER_BITWIDTH-1:0]   i_cap_value,
    input  logic [NB_INSTANCES-1:0]                  i_clear_overflow,
    output logic                                     o_out_valid,
    input  logic                                     i_out_ready,
    output logic [TIMER_BITWIDTH-1:0]                o_out_value,
    output logic [$clog2(NB_INSTANCES)-1:0]          o_out_instance,
    output logic [NB_INSTANCES-1:0]                  o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]              o_fifo_count
);

    localparam int IDX_W = $clog2(NB_INSTANCES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = IDX_W + TIMER_BITWIDTH;

    localparam logic [CNT_W-1:0]        DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]        CNT_ONE_C  = CNT_W'(1);
    localparam logic [PTR_W-1:0]        PTR_ONE_C  = PTR_W'(1);
    localparam logic [IDX_W-1:0]        LAST_IDX_C = IDX_W'(NB_INSTANCES - 1);
    localparam logic [IDX_W:0]          WIDE_ONE_C = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]          WIDE_NB_C  = (IDX_W+1)'(NB_INSTANCES);
    localparam logic [NB_INSTANCES-1:0] ONE_NB_C   = NB_INSTANCES'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NB_INSTANCES-1:0]    r_pending;
    logic [NB_INSTANCES-1:0]    r_overflow;
    logic [TIMER_BITWIDTH-1:0]  r_hold [NB_INSTANCES];
    logic [IDX_W-1:0]           r_last_grant;

    logic [ENT_W-1:0]           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                       w_any;
    logic [IDX_W-1:0]           w_grant_idx;
    logic [IDX_W:0]             w_sum;
    logic [IDX_W:0]             w_cand_wide;
    logic [IDX_W-1:0]           w_cand;
    logic                       w_hit;

    logic                       w_out_valid;
    logic                       w_push;
    logic                       w_pop;
    logic [NB_INSTANCES-1:0]    w_grant_vec;
    logic [NB_INSTANCES-1:0]    w_drop_vec;
    logic [NB_INSTANCES-1:0]    w_load_vec;
    logic [ENT_W-1:0]           w_head;

    // Round-robin search: first pending instance at or after last_grant+1, wrapping.
    always_comb begin
        w_any       = 1'b0;
        w_grant_idx = {IDX_W{1'b0}};
        w_sum       = {(IDX_W+1){1'b0}};
        w_cand_wide = {(IDX_W+1){1'b0}};
        w_cand      = {IDX_W{1'b0}};
        w_hit       = 1'b0;
        for (int k = 0; k < NB_INSTANCES; k++) begin
            // Sum stays below 2*NB_INSTANCES, so a single subtraction wraps it.
            w_sum       = {1'b0, r_last_grant} + WIDE_ONE_C + (IDX_W+1)'(k);
            w_cand_wide = (w_sum >= WIDE_NB_C) ? (w_sum - WIDE_NB_C) : w_sum;
            w_cand      = w_cand_wide[IDX_W-1:0];
            w_hit       = r_pending[w_cand] & ~w_any;
            w_grant_idx = w_hit ? w_cand : w_grant_idx;
            w_any       = w_any | w_hit;
        end
    end

    assign w_out_valid = (r_count != {CNT_W{1'b0}});

    // A grant is a push; it is refused at full occupancy even if a pop happens now.
    assign w_push      = w_any & (r_count != DEPTH_C);
    assign w_pop       = w_out_valid & i_out_ready;

    assign w_grant_vec = w_push ? (ONE_NB_C << w_grant_idx) : {NB_INSTANCES{1'b0}};

    // A capture on a held, ungranted instance is lost; a capture on a free or
    // just-granted instance replaces the holding register.
    assign w_drop_vec  = i_cap_valid & r_pending & ~w_grant_vec;
    assign w_load_vec  = i_cap_valid & (~r_pending | w_grant_vec);

    assign w_head      = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Holding registers and pending bits
    // ------------------------------------------------------------------

    // Per-instance holding register, pending bit and sticky overflow flag.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_pending  <= {NB_INSTANCES{1'b0}};
            r_overflow <= {NB_INSTANCES{1'b0}};
            for (int i = 0; i < NB_INSTANCES; i++) begin
                r_hold[i] <= {TIMER_BITWIDTH{1'b0}};
            end
        end else begin
            r_pending  <= (r_pending & ~w_grant_vec) | i_cap_valid;
            // A drop in the same cycle as a clear keeps the flag set.
            r_overflow <= w_drop_vec | (r_overflow & ~i_clear_overflow);
            for (int i = 0; i < NB_INSTANCES; i++) begin
                if (w_load_vec[i]) begin
                    r_hold[i] <= i_cap_value[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
                end else begin
                    r_hold[i] <= r_hold[i];
                end
            end
        end
    end

    // Round-robin pointer; starts at the last index so instance 0 wins first.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_last_grant <= LAST_IDX_C;
        end else if (w_push) begin
            r_last_grant <= w_grant_idx;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------

    // FIFO storage: the granted {instance, value} pair is written at the tail.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            for (int d = 0; d < FIFO_DEPTH; d++) begin
                r_mem[d] <= {ENT_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {w_grant_idx, r_hold[w_grant_idx]};
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // FIFO pointers (wrap naturally at the power-of-two depth) and occupancy.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            r_wr_ptr <= w_push ? (r_wr_ptr + PTR_ONE_C) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? (r_rd_ptr + PTR_ONE_C) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE_C;
                2'b01:   r_count <= r_count - CNT_ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all taken straight from state; head fields read as zero
    // while the FIFO is empty.
    // ------------------------------------------------------------------
    assign o_out_valid    = w_out_valid;
    assign o_out_value    = w_out_valid ? w_head[TIMER_BITWIDTH-1:0] : {TIMER_BITWIDTH{1'b0}};
    assign o_out_instance = w_out_valid ? w_head[ENT_W-1:TIMER_BITWIDTH] : {IDX_W{1'b0}};
    assign o_overflow     = r_overflow;
    assign o_fifo_count   = r_count;

endmodule

// File: tb/tb_timer_capture_collector.sv
// -----------------------------------------------------------------------------
// Self-checking bench for timer_capture_collector: directed scenarios followed
// by randomized traffic. A behavioural model tracks held captures, the
// round-robin pointer and the FIFO contents as queues. It pushes each expected
// output entry into a scoreboard that an independent monitor drains whenever
// the DUT completes a handshake.
// -----------------------------------------------------------------------------
module tb_timer_capture_collector;

    localparam int TW    = 32;
    localparam int NB    = 10;
    localparam int DEPTH = 16;
    localparam int IW    = $clog2(NB);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 areset = 1'b1;
    logic [NB-1:0]        cap_valid = '0;
    logic [NB*TW-1:0]     cap_value = '0;
    logic [NB-1:0]        clr = '0;
    logic                 out_ready = 1'b0;
    logic                 out_valid;
    logic [TW-1:0]        out_value;
    logic [IW-1:0]        out_instance;
    logic [NB-1:0]        overflow;
    logic [CW-1:0]        fifo_count;

    always #5 clk = ~clk;

    timer_capture_collector #(
        .TIMER_BITWIDTH (TW),
        .NB_INSTANCES   (NB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_areset         (areset),
        .i_cap_valid      (cap_valid),
        .i_cap_value      (cap_value),
        .i_clear_overflow (clr),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_value      (out_value),
        .o_out_instance   (out_instance),
        .o_overflow       (overflow),
        .o_fifo_count     (fifo_count)
    );

    typedef struct {
        int            inst;
        logic [TW-1:0] val;
    } ent_t;

    // Reference model state
    ent_t          m_fifo[$];
    ent_t          sb[$];
    bit            m_pend [NB];
    logic [TW-1:0] m_hold [NB];
    int            m_last = NB - 1;
    logic [NB-1:0] m_ovf = '0;

    // What the DUT actually delivered (for scenario-level checks)
    int            seen_inst[$];
    logic [TW-1:0] seen_val[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < NB; i++) b = b | m_pend[i];
        return b;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        sb.delete();
        for (int i = 0; i < NB; i++) begin
            m_pend[i] = 1'b0;
            m_hold[i] = '0;
        end
        m_ovf  = '0;
        m_last = NB - 1;
    endtask

    // One clock edge of the behaviour described by the requirements.
    task automatic model_step();
        int   g;
        ent_t e;
        g = -1;
        if (m_fifo.size() < DEPTH) begin
            for (int k = 1; k <= NB; k++) begin
                int j;
                j = (m_last + k) % NB;
                if (g < 0 && m_pend[j]) g = j;
            end
        end
        if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
        if (g >= 0) begin
            e.inst = g;
            e.val  = m_hold[g];
            m_fifo.push_back(e);
            sb.push_back(e);
            m_pend[g] = 1'b0;
            m_last    = g;
        end
        for (int i = 0; i < NB; i++) begin
            if (cap_valid[i] && m_pend[i]) begin
                m_ovf[i] = 1'b1;
            end else begin
                if (clr[i]) m_ovf[i] = 1'b0;
                if (cap_valid[i]) begin
                    m_hold[i] = cap_value[i*TW +: TW];
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    // Model follows every clock edge; reset acts asynchronously as in the DUT.
    initial begin
        forever begin
            @(posedge clk or posedge areset);
            if (areset) model_reset();
            else        model_step();
        end
    end

    // Monitor: per-cycle state comparison and scoreboard pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            check("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
            check("out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
            check("overflow", 64'(overflow), 64'(m_ovf));
            if (out_valid && out_ready) begin
                seen_inst.push_back(int'(out_instance));
                seen_val.push_back(out_value);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got inst %0d value 0x%0h, expected no entry",
                             out_instance, out_value);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    check("out_instance", 64'(out_instance), 64'(e.inst));
                    check("out_value", 64'(out_value), 64'(e.val));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        cap_valid = '0;
        clr       = '0;
    endtask

    task automatic cap1(input int inst, input logic [TW-1:0] v);
        cap_valid[inst]          = 1'b1;
        cap_value[inst*TW +: TW] = v;
    endtask

    task automatic do_reset();
        cap_valid = '0;
        clr       = '0;
        areset    = 1'b1;
        tick();
        tick();
        areset    = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || m_fifo.size() != 0 || model_busy()) && n < 300) begin
            tick();
            n++;
        end
        check(name, 64'(n < 300), 64'd1);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_value", 64'(out_value), 64'd0);
        check("reset_out_instance", 64'(out_instance), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_fifo_count", 64'(fifo_count), 64'd0);
        tick();
        areset = 1'b0;

        // Single capture latency: valid two cycles after the strobe, for one cycle.
        out_ready = 1'b1;
        cap1(3, 32'h0000_1234);
        step();
        @(negedge clk);
        check("lat_n1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_n2_valid", 64'(out_valid), 64'd1);
        check("lat_n2_value", 64'(out_value), 64'h1234);
        check("lat_n2_instance", 64'(out_instance), 64'd3);
        @(negedge clk);
        check("lat_n3_valid", 64'(out_valid), 64'd0);

        // All instances at once from reset: delivered in order 0..9.
        do_reset();
        seen_inst.delete();
        seen_val.delete();
        out_ready = 1'b1;
        for (int i = 0; i < NB; i++) cap1(i, TW'(i));
        step();
        repeat (14) tick();
        check("all_count", 64'(seen_inst.size()), 64'(NB));
        for (int i = 0; i < NB && i < seen_inst.size(); i++) begin
            check("all_order", 64'(seen_inst[i]), 64'(i));
        end
        check("all_overflow", 64'(overflow), 64'd0);

        // Full FIFO, then two captures on instance 2: first held, second dropped.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            cap1(k % NB, 32'h100 + TW'(k));
            step();
        end
        tick();
        tick();
        cap1(2, 32'hA);
        step();
        cap1(2, 32'hB);
        step();
        @(negedge clk);
        check("full_count", 64'(fifo_count), 64'd16);
        check("full_ovf2", 64'(overflow[2]), 64'd1);

        // Clear and drop together keep the flag; clear alone removes it.
        tick();
        cap1(2, 32'hC);
        clr[2] = 1'b1;
        step();
        @(negedge clk);
        check("clr_vs_set_ovf2", 64'(overflow[2]), 64'd1);
        clr[2] = 1'b1;
        step();
        @(negedge clk);
        check("clr_only_ovf2", 64'(overflow[2]), 64'd0);
        tick();
        seen_inst.delete();
        seen_val.delete();
        drain("full_drain_timeout");
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < seen_val.size(); i++) begin
            if (seen_inst[i] == 2 && seen_val[i] == 32'hA) cnt_a++;
            if (seen_val[i] == 32'hB || seen_val[i] == 32'hC) cnt_b++;
        end
        check("ovf_held_delivered", 64'(cnt_a), 64'd1);
        check("ovf_dropped_absent", 64'(cnt_b), 64'd0);

        // Recapture in the granting cycle: both values go out, no overflow.
        seen_inst.delete();
        seen_val.delete();
        cap1(5, 32'h10);
        step();
        cap1(5, 32'h11);
        step();
        repeat (6) tick();
        check("regrant_count", 64'(seen_val.size()), 64'd2);
        if (seen_val.size() >= 2) begin
            check("regrant_first", 64'(seen_val[0]), 64'h10);
            check("regrant_second", 64'(seen_val[1]), 64'h11);
        end
        check("regrant_ovf5", 64'(overflow[5]), 64'd0);

        // Reset mid-stream with 7 entries queued and three instances pending.
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cap1(k, 32'h200 + TW'(k));
            step();
        end
        tick();
        tick();
        cap1(7, 32'h307);
        cap1(8, 32'h308);
        cap1(9, 32'h309);
        step();
        check("pre_rst_count", 64'(fifo_count), 64'd7);
        areset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        tick();
        areset    = 1'b0;
        out_ready = 1'b1;
        seen_inst.delete();
        seen_val.delete();
        repeat (20) tick();
        check("post_rst_no_stale", 64'(seen_val.size()), 64'd0);
        check("post_rst_count", 64'(fifo_count), 64'd0);

        // Randomized traffic with alternating ready pressure and one reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cap_valid = NB'($urandom) & NB'($urandom);
            for (int i = 0; i < NB; i++) cap_value[i*TW +: TW] = $urandom;
            clr = NB'($urandom) & NB'($urandom) & NB'($urandom);
            if (((cyc / 400) % 2) == 0) out_ready = ($urandom_range(0, 99) < 80);
            else                        out_ready = ($urandom_range(0, 99) < 25);
            areset = (cyc == 1700);
            tick();
        end
        cap_valid = '0;
        clr       = '0;
        areset    = 1'b0;
        drain("rand_drain_timeout");
        tick();
        check("final_count", 64'(fifo_count), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/timer_capture_collector.md
TIMER_CAPTURE_COLLECTOR -- requirements
Module: timer_capture_collector

Interface
REQ-001 The block SHALL have parameter TIMER_BITWIDTH, default 32, giving the width of each captured timer value.
REQ-002 The block SHALL have parameter NB_INSTANCES, default 10, giving the number of timer instances collected.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16 (power of two, >=2), giving the shared output FIFO entries.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 areset  input  1  asynchronous, active-high reset.
REQ-006 cap_valid  input  NB_INSTANCES  per-instance one-cycle capture strobe from the timer instances.
REQ-007 cap_value  input  NB_INSTANCES*TIMER_BITWIDTH  captured values, instance i at bits [i*TIMER_BITWIDTH +: TIMER_BITWIDTH].
REQ-008 clear_overflow  input  NB_INSTANCES  per-instance one-cycle clear of the sticky overflow flag.
REQ-009 out_valid  output  1  FIFO head entry valid.
REQ-010 out_ready  input  1  consumer accepts the head entry when out_valid and out_ready are both high.
REQ-011 out_value  output  TIMER_BITWIDTH  captured value of the head entry.
REQ-012 out_instance  output  $clog2(NB_INSTANCES)  source instance index of the head entry.
REQ-013 overflow  output  NB_INSTANCES  sticky per-instance dropped-capture flags.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Each instance SHALL have a one-entry holding register with a pending bit; cap_valid[i] high at a clock edge SHALL load cap_value slice i and set pending[i].
REQ-016 The arbiter SHALL be round-robin: it grants at most one pending instance per cycle, searching from last_grant+1 upward and wrapping at NB_INSTANCES-1.
REQ-017 A grant SHALL occur only when fifo_count < FIFO_DEPTH; the granted entry {instance, value} is written into the FIFO at that clock edge and pending[i] is cleared.
REQ-018 last_grant SHALL update only on an actual grant.
REQ-019 Latency: with an idle arbiter and an empty FIFO, cap_valid in cycle N SHALL give out_valid high in cycle N+2.
REQ-020 If cap_valid[i] arrives while pending[i] is set and instance i is not granted that cycle, the new value SHALL be dropped, the held value is kept, and overflow[i] is set.
REQ-021 If cap_valid[i] arrives in the same cycle that instance i is granted, the old value SHALL go to the FIFO, the new value loads, pending stays set, and no overflow is flagged.
REQ-022 clear_overflow[i] SHALL clear overflow[i] at the next edge; a simultaneous set condition wins and the flag stays 1.
REQ-023 The FIFO SHALL be first-word-fall-through: out_value and out_instance hold the head while out_valid is high and change only after a pop.
REQ-024 A simultaneous push and pop SHALL leave fifo_count unchanged; a push is never accepted at fifo_count == FIFO_DEPTH, even with a same-cycle pop.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 While the FIFO is full, pending entries SHALL be held without loss; only new captures on already-pending instances are dropped, per REQ-020.

Reset
REQ-027 areset high SHALL immediately clear pending, overflow, FIFO pointers and fifo_count, and set last_grant to NB_INSTANCES-1 so that instance 0 has first priority.
REQ-028 During and after reset: out_valid=0, out_value=0, out_instance=0, overflow=0, fifo_count=0.
REQ-029 areset asserted mid-operation SHALL discard all pending and FIFO contents; no partial entry is output after release.

Verification
REQ-030 Single capture: cap_valid[3]=1 with value 0x0000_1234 in cycle N, out_ready=1 -> out_valid=1 in cycle N+2 with out_value=0x1234 and out_instance=3 for one cycle.
REQ-031 Simultaneous captures: cap_valid=all ones with value_i=i, out_ready=1 -> outputs in instance order 0..9 on consecutive cycles, overflow=0.
REQ-032 Overflow: out_ready=0, fill FIFO with 16 captures, then instance 2 captures 0xA then 0xB -> fifo_count=16, overflow[2]=1; raise out_ready -> 0xA delivered from instance 2, 0xB never delivered.
REQ-033 Same-cycle grant and recapture: pending[5]=0x10 granted while a new capture 0x11 arrives -> both 0x10 and 0x11 are output, overflow[5]=0.
REQ-034 Clear versus set: clear_overflow[2]=1 in the same cycle as a new drop on instance 2 -> overflow[2] remains 1; clear alone in the next cycle -> 0.
REQ-035 Reset mid-stream: areset pulsed with fifo_count=7 and three instances pending -> out_valid=0 and fifo_count=0 immediately; after release, no stale entries appear.
